// File: rtl/conv_in_ctrl.sv
// Conv input controller: sequences one layer pass of BRAM window beats with read-latency-aware backpressure.
// Optional CONV_IN_CTRL_PERF_EN adds saturating stall_cnt/run_cnt performance counters.
module conv_in_ctrl #(
  parameter int BRAM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [11:0] width,
  input  logic [11:0] channel,
  input  logic        out_ready,
  output logic        gen_rst,
  output logic        addr_inc,
  output logic [11:0] cfg_width,
  output logic [11:0] cfg_channel,
  output logic        rd_en,
  output logic        win_valid,
  output logic        win_last,
  output logic        busy,
  output logic        done,
  output logic        cfg_err
`ifdef CONV_IN_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] run_cnt
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_INIT  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]          state;
  logic [35:0]         beats_left;
  logic [BRAM_LAT-1:0] v;
  logic [BRAM_LAT-1:0] lst;
  logic                abort_q;
  logic                adv;
  logic                cfg_ok;
  logic                accept;
  logic                do_abort;
  logic                final_hs;
  logic                last_inc;
  logic [35:0]         beat_total;

  // The output register only advances when its beat is consumed or it holds a bubble.
  assign adv        = ~v[BRAM_LAT-1] | out_ready;
  assign cfg_ok     = (width >= 12'd3) && (channel != 12'd0);
  assign accept     = (state == S_IDLE) && start;
  assign do_abort   = abort && (state != S_IDLE);
  assign final_hs   = (state == S_DRAIN) && win_valid && win_last && out_ready;
  assign beat_total = 36'(width) * 36'(width - 12'd2) * 36'(channel);
  assign addr_inc   = (state == S_RUN) && adv && (beats_left != 36'd0);
  assign last_inc   = addr_inc && (beats_left == 36'd1);
  assign rd_en      = adv & ~rst;
  assign win_valid  = v[BRAM_LAT-1];
  assign win_last   = win_valid & lst[BRAM_LAT-1];
  assign busy       = (state != S_IDLE);
  assign gen_rst    = rst | (state == S_INIT) | abort_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      beats_left  <= 36'd0;
      v           <= '0;
      lst         <= '0;
      abort_q     <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      cfg_width   <= 12'd0;
      cfg_channel <= 12'd0;
    end else begin
      abort_q <= do_abort;
      done    <= final_hs & ~do_abort;
      cfg_err <= accept & ~cfg_ok;
      if (do_abort) begin
        state      <= S_IDLE;
        beats_left <= 36'd0;
        v          <= '0;
        lst        <= '0;
      end else begin
        if (adv) begin
          v   <= (v << 1) | BRAM_LAT'(addr_inc);
          lst <= (lst << 1) | BRAM_LAT'(last_inc);
        end
        if (addr_inc)
          beats_left <= beats_left - 36'd1;
        case (state)
          S_IDLE: begin
            if (accept && cfg_ok) begin
              cfg_width   <= width;
              cfg_channel <= channel;
              beats_left  <= beat_total;
              state       <= S_INIT;
            end
          end
          S_INIT:  state <= S_RUN;
          S_RUN:   if (last_inc) state <= S_DRAIN;
          S_DRAIN: if (final_hs) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef CONV_IN_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || (accept && cfg_ok)) begin
      stall_cnt <= 32'd0;
      run_cnt   <= 32'd0;
    end else begin
      if (win_valid && !out_ready && !(&stall_cnt))
        stall_cnt <= stall_cnt + 32'd1;
      if (busy && !(&run_cnt))
        run_cnt <= run_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_in_ctrl.sv
// Randomised self-checking bench for conv_in_ctrl against a beat-count / latency reference model.
module tb_conv_in_ctrl;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [11:0] width, channel;
  logic        gen_rst, addr_inc, rd_en, win_valid, win_last, busy, done, cfg_err;
  logic [11:0] cfg_width, cfg_channel;
`ifdef CONV_IN_CTRL_PERF_EN
  logic [31:0] stall_cnt, run_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cfg_w_model = 0;

  always #5 clk = ~clk;

  conv_in_ctrl #(.BRAM_LAT(L)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .width(width), .channel(channel), .out_ready(out_ready),
    .gen_rst(gen_rst), .addr_inc(addr_inc),
    .cfg_width(cfg_width), .cfg_channel(cfg_channel),
    .rd_en(rd_en), .win_valid(win_valid), .win_last(win_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef CONV_IN_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .run_cnt(run_cnt)
`endif
  );

  // One full pass; mode 0: ready held high, 1: ready toggles, 2: random ready.
  task automatic run_pass(input int w, input int c, input int mode);
    int n, issued, accepted, first_addr, first_valid, final_k, done_k, done_cnt;
    int last_bad, stall_bad, out_bad, stray;
    n = w * (w - 2) * c;
    issued = 0; accepted = 0; first_addr = -1; first_valid = -1;
    final_k = -1; done_k = -1; done_cnt = 0;
    last_bad = 0; stall_bad = 0; out_bad = 0; stray = 0;
    @(negedge clk);
    width = 12'(w); channel = 12'(c); start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (gen_rst !== 1'b1 || busy !== 1'b1 || addr_inc !== 1'b0 || cfg_width !== 12'(w) || cfg_channel !== 12'(c)) begin
      errors++;
      $display("FAIL init_cycle w=%0d c=%0d: gen_rst=%b busy=%b addr_inc=%b cfg=%0d/%0d, required 1 1 0 %0d/%0d",
               w, c, gen_rst, busy, addr_inc, cfg_width, cfg_channel, w, c);
    end
    cfg_w_model = w;
    for (int k = 1; k < 4000; k++) begin
      @(negedge clk);
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = ((k % 2) == 1);
      else out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (issued - accepted > L) out_bad++;
      if (gen_rst || cfg_err) stray++;
      if (win_valid && !out_ready && (addr_inc || rd_en)) stall_bad++;
      if (addr_inc) begin
        if (first_addr < 0) first_addr = k;
        issued++;
      end
      if (win_valid && first_valid < 0) first_valid = k;
      if (win_valid && out_ready) begin
        accepted++;
        if (win_last !== (accepted == n)) last_bad++;
        if (accepted == n) final_k = k;
      end
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      if (final_k >= 0 && k >= final_k + 3) break;
    end
    checks++;
    if (final_k < 0) begin
      errors++;
      $display("FAIL pass_timeout w=%0d c=%0d: accepted %0d beats, required %0d", w, c, accepted, n);
    end
    checks++;
    if (issued != n) begin
      errors++;
      $display("FAIL addr_inc_count w=%0d c=%0d: got %0d, required %0d", w, c, issued, n);
    end
    checks++;
    if (accepted != n) begin
      errors++;
      $display("FAIL beat_count w=%0d c=%0d: got %0d, required %0d", w, c, accepted, n);
    end
    checks++;
    if (first_addr != 1) begin
      errors++;
      $display("FAIL first_addr_inc w=%0d c=%0d: cycle %0d after INIT, required 1", w, c, first_addr);
    end
    checks++;
    if (last_bad != 0) begin
      errors++;
      $display("FAIL win_last_pos w=%0d c=%0d: %0d misplaced, required 0", w, c, last_bad);
    end
    checks++;
    if (done_cnt != 1 || done_k != final_k + 1) begin
      errors++;
      $display("FAIL done_pulse w=%0d c=%0d: count=%0d at cycle %0d, required 1 at %0d", w, c, done_cnt, done_k, final_k + 1);
    end
    checks++;
    if (stall_bad != 0 || out_bad != 0) begin
      errors++;
      $display("FAIL stall_rule w=%0d c=%0d: stall_viol=%0d overfill=%0d, required 0 0", w, c, stall_bad, out_bad);
    end
    checks++;
    if (stray != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_or_busy w=%0d c=%0d: stray=%0d busy=%b, required 0 0", w, c, stray, busy);
    end
    if (mode == 0) begin
      checks++;
      if (first_valid != first_addr + L || final_k != first_valid + n - 1) begin
        errors++;
        $display("FAIL latency_b2b w=%0d c=%0d: first_valid=%0d final=%0d, required %0d %0d",
                 w, c, first_valid, final_k, first_addr + L, first_addr + L + n - 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; width = 12'd0; channel = 12'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({gen_rst, addr_inc, rd_en, win_valid, win_last, busy, done, cfg_err} !== 8'b1000_0000 ||
        cfg_width !== 12'd0 || cfg_channel !== 12'd0) begin
      errors++;
      $display("FAIL reset_state: outs=%b cfg=%0d/%0d, required 10000000 0/0",
               {gen_rst, addr_inc, rd_en, win_valid, win_last, busy, done, cfg_err}, cfg_width, cfg_channel);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (gen_rst !== 1'b0 || rd_en !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: gen_rst=%b rd_en=%b busy=%b, required 0 1 0", gen_rst, rd_en, busy);
    end
  endtask

  task automatic test_cfg_err(input int w, input int c);
    @(negedge clk);
    width = 12'(w); channel = 12'(c); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || gen_rst !== 1'b0 || cfg_width !== 12'(cfg_w_model)) begin
      errors++;
      $display("FAIL cfg_err_pulse w=%0d c=%0d: cfg_err=%b busy=%b gen_rst=%b cfg_w=%0d, required 1 0 0 %0d",
               w, c, cfg_err, busy, gen_rst, cfg_width, cfg_w_model);
    end
    @(negedge clk);
    #1;
    checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_single w=%0d c=%0d: cfg_err=%b busy=%b, required 0 0", w, c, cfg_err, busy);
    end
  endtask

  task automatic test_abort();
    int issued;
    int bad;
    issued = 0; bad = 0;
    @(negedge clk);
    width = 12'd6; channel = 12'd3; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200 && issued < 10; k++) begin
      @(negedge clk);
      #1;
      if (addr_inc) issued++;
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || gen_rst !== 1'b1 || win_valid !== 1'b0 || done !== 1'b0 || issued != 10) begin
      errors++;
      $display("FAIL abort_next: busy=%b gen_rst=%b win_valid=%b done=%b issued=%0d, required 0 1 0 0 10",
               busy, gen_rst, win_valid, done, issued);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (gen_rst || done || win_valid || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d bad cycles, required 0", bad);
    end
    run_pass(6, 3, 0);
  endtask

  task automatic test_rst_drain();
    int bad;
    bad = 0;
    @(negedge clk);
    width = 12'd3; channel = 12'd1; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || win_valid !== 1'b1) begin
      errors++;
      $display("FAIL drain_hold: busy=%b win_valid=%b, required 1 1", busy, win_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({gen_rst, addr_inc, rd_en, win_valid, win_last, busy, done, cfg_err} !== 8'b1000_0000 ||
        cfg_width !== 12'd0 || cfg_channel !== 12'd0) begin
      errors++;
      $display("FAIL rst_in_drain: outs=%b cfg=%0d/%0d, required 10000000 0/0",
               {gen_rst, addr_inc, rd_en, win_valid, win_last, busy, done, cfg_err}, cfg_width, cfg_channel);
    end
    rst = 1'b0;
    cfg_w_model = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (done || cfg_err || win_valid || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_discard: %0d bad cycles, required 0", bad);
    end
    run_pass(5, 2, 0);
  endtask

  task automatic test_wide();
    longint n;
    int issued, accepted;
    n = longint'(4095) * 4093 * 4095;
    issued = 0; accepted = 0;
    @(negedge clk);
    width = 12'd4095; channel = 12'd4095; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (dut.beats_left !== 36'(n)) begin
      errors++;
      $display("FAIL wide_load: beats_left=%0d, required %0d", dut.beats_left, n);
    end
    for (int k = 0; k < 400 && accepted < 100; k++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (addr_inc) issued++;
      if (win_valid && out_ready) accepted++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (accepted != 100 || dut.beats_left !== 36'(n - issued) || busy !== 1'b1) begin
      errors++;
      $display("FAIL wide_count: accepted=%0d beats_left=%0d busy=%b, required 100 %0d 1",
               accepted, dut.beats_left, busy, n - issued);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || win_valid !== 1'b0 || gen_rst !== 1'b1) begin
      errors++;
      $display("FAIL wide_abort: busy=%b win_valid=%b gen_rst=%b, required 0 0 1", busy, win_valid, gen_rst);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++)
      run_pass($urandom_range(3, 7), $urandom_range(1, 3), 2);
  endtask

  initial begin
    test_reset();
    run_pass(5, 2, 0);
    test_cfg_err(2, 1);
    test_cfg_err(5, 0);
    run_pass(3, 1, 0);
    run_pass(4, 1, 1);
    test_abort();
    test_rst_drain();
    test_wide();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_in_ctrl.md
CONV_IN_CTRL -- requirements
Module: conv_in_ctrl

Interface
REQ-001 Parameter BRAM_LAT, default 2, input-BRAM read latency in cycles (legal 1..4).
REQ-002 clk  input  1  clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin one layer pass.
REQ-005 abort  input  1  cancel current pass.
REQ-006 width, channel  input  12 each  feature-map width and channel count, sampled on accepted start.
REQ-007 out_ready  input  1  downstream PE array accepts a window beat.
REQ-008 gen_rst  output  1  synchronous reset to the address generator.
REQ-009 addr_inc  output  1  advance address generator.
REQ-010 cfg_width, cfg_channel  output  12 each  latched configuration driven to address generator.
REQ-011 rd_en  output  1  BRAM read/output-register enable.
REQ-012 win_valid  output  1  window beat valid at BRAM output.
REQ-013 win_last  output  1  final beat of pass, qualified by win_valid.
REQ-014 busy, done, cfg_err  output  1 each  status; done and cfg_err are one-cycle pulses.

Function
REQ-015 States IDLE, INIT, RUN, DRAIN; encoding free.
REQ-016 IDLE+start with width>=3 and channel>=1: latch cfg, load beat counter with width*(width-2)*channel (36-bit, no truncation), go INIT.
REQ-017 IDLE+start with width<3 or channel==0: pulse cfg_err next cycle, remain IDLE, cfg unchanged.
REQ-018 start while not IDLE SHALL be ignored.
REQ-019 INIT lasts exactly one cycle with gen_rst=1, then RUN; gen_rst=0 in all other states.
REQ-020 adv = ~v[BRAM_LAT-1] | out_ready, where v is a BRAM_LAT-deep valid shift register; rd_en=adv.
REQ-021 addr_inc = (state==RUN) & adv & (beats_left!=0); each addr_inc decrements beats_left.
REQ-022 On adv, v shifts with addr_inc as input; when adv=0, v and the last-flag pipeline hold.
REQ-023 win_valid=v[BRAM_LAT-1]; win_last=win_valid & (last-flag, set on the addr_inc decrementing beats_left 1->0).
REQ-024 RUN->DRAIN in the cycle the final addr_inc issues; DRAIN->IDLE when win_valid&win_last&out_ready, with done pulsed the following cycle.
REQ-025 First addr_inc occurs the cycle after INIT; with out_ready held 1, first win_valid appears BRAM_LAT cycles after first addr_inc and beats are back-to-back.
REQ-026 busy=1 in INIT, RUN, DRAIN.
REQ-027 abort in any non-IDLE state: next cycle IDLE, v and last-flag cleared, gen_rst pulsed one cycle, no done; abort in IDLE ignored; abort takes priority over start and completion in the same cycle.
REQ-028 Simultaneous final handshake and out_ready drop cannot lose a beat: a beat leaves only on win_valid&out_ready.

Reset
REQ-029 rst: state=IDLE, v=0, last-flag=0, beats_left=0, cfg_width=0, cfg_channel=0, all 1-bit outputs 0 except gen_rst=1 during rst.
REQ-030 rst mid-pass SHALL discard all in-flight beats without done or cfg_err.

Configuration
REQ-031 Macro CONV_IN_CTRL_PERF_EN defined: add outputs stall_cnt[31:0] (cycles with win_valid&~out_ready) and run_cnt[31:0] (cycles busy), cleared on accepted start and rst, saturating at all-ones.
REQ-032 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-033 width=5, channel=2, out_ready=1, BRAM_LAT=2: 30 addr_inc, 30 win_valid beats, win_last on beat 30, done 1 cycle after.
REQ-034 width=2 start -> cfg_err pulse, busy stays 0, no gen_rst; then width=3, channel=1 -> 3 beats, done.
REQ-035 width=4, channel=1, out_ready toggling 1/0 per cycle -> exactly 8 beats accepted, no addr_inc while pipeline full and stalled.
REQ-036 width=6, channel=3, abort after 10th addr_inc -> IDLE next cycle, gen_rst pulse, win_valid 0, no done; restart completes 72 beats.
REQ-037 rst asserted in DRAIN -> all outputs at reset values next cycle, following start runs normally.
REQ-038 width=4095, channel=4095 -> beat counter loads 4095*4093*4095 without overflow (check value, abort after 100 beats).
